sram_resp: RTL
==============

Name: sram_resp

Overview:
- Synchronous single-port SRAM responder: the memory-side end of the s_cen/s_wen/s_oen/s_addr/s_ddata/s_qdata interface driven by sram_ctrl.
- Used as the on-FPGA inner SRAM and as the bench memory for controller verification.
- Adds a configurable read pipeline, access counters and protocol-violation detection, exported as 32-bit words for the AXI register bank.

Parameters:
- DATA_W, 8, data width of s_ddata/s_qdata.
- ADDR_W, 10, address width; depth = 2**ADDR_W (1024), full decode.
- RD_LAT, 1, read latency in clk cycles from sampling edge to s_qdata update; legal 1..4.

Ports:
- clk  in  1  system clock; the SRAM clock is the same as the controller clock.
- reset_n  in  1  asynchronous active-low reset.
- s_cen  in  1  chip enable, active high.
- s_wen  in  1  write enable, active high.
- s_oen  in  1  output/read enable, active high.
- s_addr  in  ADDR_W  access address.
- s_ddata  in  DATA_W  write data.
- s_qdata  out  DATA_W  read data.
- cnt_clr  in  1  one-cycle pulse; clears wr_cnt, rd_cnt, err_cnt.
- err_clr  in  1  one-cycle pulse; clears err_flag and err_addr.
- wr_cnt  out  32  completed writes, saturating.
- rd_cnt  out  32  issued reads, saturating.
- err_cnt  out  32  protocol violations, saturating.
- err_flag  out  1  sticky violation flag.
- err_addr  out  32  s_addr of the first violation since the last clear, zero-extended.

Behaviour:
- Reset (async assert, sync release):
  - s_qdata=0; all counters=0; err_flag=0; err_addr=0; read pipeline valid bits=0.
  - Memory array is NOT reset; contents survive reset_n pulses, including resets mid-operation.
  - Reads in flight at reset are discarded.
- Each rising edge, s_cen/s_wen/s_oen are decoded:
  - s_cen=0: idle; s_wen/s_oen are ignored and no error is raised.
  - s_cen=1, s_wen=1, s_oen=0: write; mem[s_addr]<=s_ddata; wr_cnt+1.
  - s_cen=1, s_wen=0, s_oen=1: read issued; mem[s_addr] enters the pipeline at stage 1; rd_cnt+1.
  - s_cen=1, s_wen=0, s_oen=0: selected but no operation; no effect.
  - s_cen=1, s_wen=1, s_oen=1: violation.
    - No write; no read issued.
    - err_cnt+1; err_flag<=1.
    - err_addr<=s_addr only if err_flag was 0, so the first violation is kept.
- Read pipeline:
  - RD_LAT stages, each holding {valid, data}; advances every cycle.
  - When stage RD_LAT is valid, s_qdata<=its data.
  - Otherwise s_qdata holds its previous value. It never returns to 0 except on reset.
  - Back-to-back reads are fully pipelined, one per cycle; with RD_LAT=1, read at edge N updates s_qdata at edge N+1.
- Read data is captured at the issuing edge:
  - A write to the same address on the next cycle does not alter the read already in flight.
  - Read on edge N+1 after a write on edge N returns the new data.
- Counters:
  - Increment by 1 per qualifying edge and saturate at 32'hFFFF_FFFF.
  - If cnt_clr is asserted on the same edge as an increment, clear wins (result 0).
- err_clr on the same edge as a violation: clear wins for err_flag and err_addr. err_cnt still increments, since only cnt_clr clears it.
- Address: all 2**ADDR_W locations valid; no out-of-range case, no wrap logic. Index with s_addr directly.
- Out-of-range RD_LAT (outside 1..4) must fail elaboration.

Test Plan:
- Reset then write: s_cen=1, s_wen=1, s_oen=0 with addr 0x000..0x3FF, data=addr[7:0]. Then stream reads 0x000..0x3FF with RD_LAT=1 -> s_qdata=addr[7:0] one cycle after each issuing edge; wr_cnt=1024, rd_cnt=1024, err_cnt=0.
- RD_LAT=3: read addr 0x155 (holding 0xA5) at edge N, then s_cen=0 -> s_qdata unchanged through edge N+2, =0xA5 at N+3, and holds 0xA5 afterwards.
- Violation: s_cen=1, s_wen=1, s_oen=1 at addr 0x2AA with s_ddata=0x3C, then the same at 0x011 -> mem[0x2AA] unchanged; err_flag=1; err_addr=0x2AA; err_cnt=2. Then err_clr -> err_flag=0, err_addr=0, err_cnt=2. Violation with s_cen=0 -> no change.
- Write 0x5A to 0x100, reset_n low for 2 cycles mid-stream, then read 0x100 -> s_qdata=0 and counters=0 during reset; read returns 0x5A; a read issued in the reset cycle never appears.
- Read 0x010 (old 0x11) at edge N, write 0x22 to 0x010 at edge N+1, read 0x010 at edge N+2 (RD_LAT=1) -> s_qdata=0x11 at N+1, 0x22 at N+3.
- Force wr_cnt to 32'hFFFF_FFFE, then do 3 writes -> wr_cnt stays 32'hFFFF_FFFF. cnt_clr coincident with a write -> wr_cnt=0 next cycle.

Source files
------------

// File: rtl/sram_resp_if.sv
// SRAM bus between sram_ctrl (master) and the memory-side responder (slave).
// Strobes are sampled on every rising clk; there is no valid/ready backpressure.
interface sram_resp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) ();
    logic              s_cen;
    logic              s_wen;
    logic              s_oen;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_ddata;
    logic [DATA_W-1:0] s_qdata;

    modport master (output s_cen, output s_wen, output s_oen,
                    output s_addr, output s_ddata, input s_qdata);
    modport slave  (input s_cen, input s_wen, input s_oen,
                    input s_addr, input s_ddata, output s_qdata);
endinterface

// File: rtl/sram_resp.sv
// Single-port SRAM responder with a configurable read pipeline, saturating
// access counters and detection of simultaneous write/read strobes.
module sram_resp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    sram_resp_if.slave  bus,
    input  logic        cnt_clr,
    input  logic        err_clr,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt,
    output logic [31:0] err_cnt,
    output logic        err_flag,
    output logic [31:0] err_addr
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sram_resp: RD_LAT must be in 1..4");
    end

    localparam int DEPTH = 2 ** ADDR_W;

    // Memory array deliberately has no reset so contents survive reset_n pulses.
    logic [DATA_W-1:0] mem [DEPTH];

    logic do_wr;
    logic do_rd;
    logic do_err;

    always_comb begin
        do_wr  = bus.s_cen &  bus.s_wen & ~bus.s_oen;
        do_rd  = bus.s_cen & ~bus.s_wen &  bus.s_oen;
        do_err = bus.s_cen &  bus.s_wen &  bus.s_oen;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[bus.s_addr] <= bus.s_ddata;
        end
    end

    logic [RD_LAT:1]   pipe_vld;
    logic [DATA_W-1:0] pipe_dat [1:RD_LAT];

    // Stage 1 captures the array at the issuing edge, so a later write cannot alter it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld    <= '0;
            bus.s_qdata <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[1] <= do_rd;
            pipe_dat[1] <= mem[bus.s_addr];
            for (int i = 2; i <= RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            if (pipe_vld[RD_LAT]) begin
                bus.s_qdata <= pipe_dat[RD_LAT];
            end
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A clear pulse on the same edge as an increment wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else if (cnt_clr) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (do_wr)  wr_cnt  <= sat_inc(wr_cnt);
            if (do_rd)  rd_cnt  <= sat_inc(rd_cnt);
            if (do_err) err_cnt <= sat_inc(err_cnt);
        end
    end

    // err_addr keeps only the first violation seen since the last clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (do_err) begin
            err_flag <= 1'b1;
            if (!err_flag) begin
                err_addr <= 32'(bus.s_addr);
            end
        end
    end

endmodule
